cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Arbitrates completed results from several functional-unit sources (adder reservation stations, load buffer, store buffer) onto the single Common Data Bus. It accepts each result via valid/ready, buffers at most one result per source, grants one source per cycle, and drives a registered one-cycle broadcast consumed by the register file write port and all reservation-station tag comparators. It sits directly upstream of the CDB write-back logic and replaces the single `done` strobe with a contention-safe, back-pressured path.

## Interface
- `NSRC`, 3: number of result sources (0 = add/sub RS, 1 = load buffer, 2 = store buffer).
- `DATA_W`, 16: result data width.
- `TAG_W`, 3: destination register tag width (R1..R7; tag 0 = no destination).
- `OP_W`, 4: opcode width (ADD.D 0000, SUB.D 0001, L.D 0010, S.D 0011).
- `clock`  in  1  single clock, all state on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `src_valid`  in  NSRC  source i presents a result.
- `src_ready`  out  NSRC  source i's result is accepted at this edge if valid.
- `src_data`  in  NSRC*DATA_W  flattened results, source i at [i*DATA_W +: DATA_W].
- `src_tag`  in  NSRC*TAG_W  flattened destination tags.
- `src_op`  in  NSRC*OP_W  flattened opcodes.
- `cdb_valid`  out  1  broadcast valid, one-cycle pulse per result.
- `cdb_we`  out  1  register write enable: `cdb_valid` and op in {ADD.D, SUB.D, L.D} and tag ≠ 0.
- `cdb_data`  out  DATA_W  broadcast data.
- `cdb_tag`  out  TAG_W  broadcast destination tag.
- `cdb_op`  out  OP_W  broadcast opcode.
- `cdb_src`  out  clog2(NSRC)  index of the granted source.
- `cdb_count`  out  16  count of broadcasts since reset, wraps 0xFFFF→0x0000.

## Operation
- Per source: one holding slot {full, data, tag, op}. Handshake `src_valid[i] & src_ready[i]` at an edge loads the slot and sets full.
- `src_ready[i] = ~full[i] | grant[i]`: a slot granted this cycle may be refilled at the same edge (full stays 1, new contents).
- Grant: combinational, exactly one among full slots, none if all empty. Granted slot clears at the edge unless refilled.
- Output register: at each edge, loads the granted slot's contents with `cdb_valid`=1; if no grant, `cdb_valid`=0 and data/tag/op/src hold previous values.
- `cdb_we` is combinational from the output register.
- S.D results (op 0011) broadcast with `cdb_we`=0; the data carries the store address/value for the memory path downstream.
- Tag 0 with ADD/SUB/LD: broadcast, `cdb_we`=0.
- `cdb_count` increments on every edge that sets `cdb_valid`.
- Reset: all slots empty, pointer = 0, `cdb_valid`=0, `cdb_data`=0, `cdb_tag`=0, `cdb_op`=0, `cdb_src`=0, `cdb_count`=0; `src_ready` = all ones the cycle after reset. Results in flight at reset are dropped.
- Simultaneous reset and handshake: reset wins; no slot loaded.

## Timing
- Latency: handshake at edge k → `cdb_valid` high for the cycle after edge k+1 if uncontended. Minimum 2 edges source-to-bus.
- Throughput: one broadcast per cycle aggregate; a single source streaming alone sustains one per cycle.
- Contention: with m full slots, each is broadcast within m cycles under round-robin.
- No back-pressure from the CDB consumer; the bus is never stalled.

## Configuration
- `CDB_ARB_RR_EN` defined: round-robin. Pointer p; search order p, p+1, … mod NSRC; after a grant to i, p ← (i+1) mod NSRC; no grant leaves p unchanged.
- Not defined: fixed priority, lowest index wins; pointer logic absent; source 0 may starve others.

## Structure
- Package `cdb_pkg`: opcode constants `OP_ADD`, `OP_SUB`, `OP_LD`, `OP_SD`, default widths, and a function `op_writes_reg(op)`.
- Sub-module `rr_arbiter`: NSRC request vector in, one-hot grant plus encoded index out, and the pointer register. It is instantiated only under `CDB_ARB_RR_EN`; otherwise an inline priority encoder is used.

## Test plan
- Single add: src0 valid at edge 1 with data 0x0042, tag 3, op 0000 → edge 2 `cdb_valid`=1, `cdb_we`=1, data 0x0042, tag 3, `cdb_src`=0, `cdb_count`=1; next cycle `cdb_valid`=0.
- Three-way contention, RR on: all sources valid once at the same edge → broadcasts in order src0, src1, src2 on three consecutive cycles. RR off: same order. Then src0 refilled continuously: RR on still grants src1 and src2 in turn, RR off grants src0 only.
- Store filter: src2 op 0011, tag 5, data 0x0010 → `cdb_valid`=1, `cdb_we`=0. Load with tag 0 → `cdb_valid`=1, `cdb_we`=0.
- Streaming and back-pressure: src1 valid every cycle, alone → one broadcast per cycle, `src_ready[1]` stays 1. With src0 also full → `src_ready[1]` drops while src1's slot waits.
- Reset mid-operation: fill all three slots, assert `Reset` one cycle → no broadcast of the dropped results, all outputs 0, `cdb_count`=0, `src_ready`=3'b111.
- Counter wrap: preload via 65535 broadcasts → next broadcast makes `cdb_count`=0x0000.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared constants, slot layout and opcode decode for the CDB arbiter.
package cdb_pkg;
  localparam int NSRC   = 3;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 16;
  localparam int SRC_W  = $clog2(NSRC);

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_LD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SD  = 4'b0011;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic [OP_W-1:0]   op;
  } slot_t;

  // Stores carry address/value for the memory path and never write the register file.
  function automatic logic op_writes_reg(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LD);
  endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// Source result handshakes plus the registered CDB broadcast, flattened per source.
interface cdb_arbiter_if;
  import cdb_pkg::*;

  logic [NSRC-1:0]        src_valid;
  logic [NSRC-1:0]        src_ready;
  logic [NSRC*DATA_W-1:0] src_data;
  logic [NSRC*TAG_W-1:0]  src_tag;
  logic [NSRC*OP_W-1:0]   src_op;

  logic              cdb_valid;
  logic              cdb_we;
  logic [DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0]  cdb_tag;
  logic [OP_W-1:0]   cdb_op;
  logic [SRC_W-1:0]  cdb_src;
  logic [CNT_W-1:0]  cdb_count;

  modport master (
    output src_valid, src_data, src_tag, src_op,
    input  src_ready, cdb_valid, cdb_we, cdb_data, cdb_tag, cdb_op, cdb_src, cdb_count
  );

  modport slave (
    input  src_valid, src_data, src_tag, src_op,
    output src_ready, cdb_valid, cdb_we, cdb_data, cdb_tag, cdb_op, cdb_src, cdb_count
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant over the full slots; search starts at ptr, ptr moves past each winner.
module rr_arbiter
  import cdb_pkg::*;
(
  input  logic             clock,
  input  logic             Reset,
  input  logic [NSRC-1:0]  req,
  output logic [NSRC-1:0]  grant,
  output logic [SRC_W-1:0] grant_idx
);
  logic [SRC_W-1:0] ptr;
  logic [SRC_W:0]   cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NSRC; k++) begin
      cand = {1'b0, ptr} + (SRC_W+1)'(k);
      if (cand >= (SRC_W+1)'(NSRC)) cand = cand - (SRC_W+1)'(NSRC);
      if (!found && req[cand[SRC_W-1:0]]) begin
        found                   = 1'b1;
        grant[cand[SRC_W-1:0]]  = 1'b1;
        grant_idx               = cand[SRC_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grant_idx == SRC_W'(NSRC-1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// One holding slot per source, one grant per cycle onto a registered CDB broadcast.
// CDB_ARB_RR_EN selects round-robin; otherwise lowest index wins.
module cdb_arbiter
  import cdb_pkg::*;
(
  input  logic         clock,
  input  logic         Reset,
  cdb_arbiter_if.slave bus
);
  slot_t            slot [NSRC];
  logic [NSRC-1:0]  full;
  logic [NSRC-1:0]  grant;
  logic [NSRC-1:0]  take;
  logic [SRC_W-1:0] gnt_idx;

  logic             cdb_valid_q;
  slot_t            cdb_q;
  logic [SRC_W-1:0] src_q;
  logic [CNT_W-1:0] count_q;

`ifdef CDB_ARB_RR_EN
  rr_arbiter u_rr (
    .clock     (clock),
    .Reset     (Reset),
    .req       (full),
    .grant     (grant),
    .grant_idx (gnt_idx)
  );
`else
  logic found;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (!found && full[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gnt_idx  = SRC_W'(i);
      end
    end
  end
`endif

  // A slot draining this cycle can take a new result at the same edge.
  assign bus.src_ready = ~full | grant;
  assign take          = bus.src_valid & bus.src_ready;

  always_ff @(posedge clock) begin
    if (Reset) begin
      full <= '0;
      for (int i = 0; i < NSRC; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (take[i]) begin
          full[i] <= 1'b1;
          slot[i] <= '{data: bus.src_data[i*DATA_W +: DATA_W],
                       tag:  bus.src_tag[i*TAG_W +: TAG_W],
                       op:   bus.src_op[i*OP_W +: OP_W]};
        end else if (grant[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
      src_q       <= '0;
      count_q     <= '0;
    end else if (|grant) begin
      cdb_valid_q <= 1'b1;
      cdb_q       <= slot[gnt_idx];
      src_q       <= gnt_idx;
      count_q     <= count_q + CNT_W'(1);
    end else begin
      cdb_valid_q <= 1'b0;
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_we    = cdb_valid_q & op_writes_reg(cdb_q.op) & (cdb_q.tag != '0);
  assign bus.cdb_data  = cdb_q.data;
  assign bus.cdb_tag   = cdb_q.tag;
  assign bus.cdb_op    = cdb_q.op;
  assign bus.cdb_src   = src_q;
  assign bus.cdb_count = count_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench: expected broadcasts queued as stimulus is driven, checked as the CDB fires.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  tag;
    logic [3:0]  op;
    logic [1:0]  src;
    logic        we;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [15:0] exp_cnt = 16'h0;

  cdb_arbiter_if bus();

  cdb_arbiter dut (
    .clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic v, input logic [15:0] d,
                       input logic [2:0] t, input logic [3:0] op);
    bus.src_valid[s]         = v;
    bus.src_data[s*16 +: 16] = d;
    bus.src_tag[s*3 +: 3]    = t;
    bus.src_op[s*4 +: 4]     = op;
  endtask

  task automatic push(input int s, input logic [15:0] d, input logic [2:0] t, input logic [3:0] op);
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    e.data = d;
    e.tag  = t;
    e.op   = op;
    e.src  = 2'(s);
    e.we   = ((op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010)) && (t != 3'd0);
    e.cnt  = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    bus.src_valid = '0;
    rst = 1'b1;
    sb.delete();
    exp_cnt = 16'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int w = 0;
    while (sb.size() != 0 && w < maxc) begin
      tick();
      w++;
    end
    tick();
    tick();
    chk("drain_empty", sb.size(), 0);
  endtask

  // Scoreboard side: every broadcast must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() == 0) begin
      chk("mon_idle", bus.cdb_valid, 1'b0);
    end else if (bus.cdb_valid === 1'b1) begin
      e = sb.pop_front();
      chk("mon_data",  bus.cdb_data,  e.data);
      chk("mon_tag",   bus.cdb_tag,   e.tag);
      chk("mon_op",    bus.cdb_op,    e.op);
      chk("mon_src",   bus.cdb_src,   e.src);
      chk("mon_we",    bus.cdb_we,    e.we);
      chk("mon_count", bus.cdb_count, e.cnt);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.src_valid = '0;
    bus.src_data  = '0;
    bus.src_tag   = '0;
    bus.src_op    = '0;

    // Reset state
    tick();
    tick();
    chk("rst_valid", bus.cdb_valid, 1'b0);
    chk("rst_we",    bus.cdb_we,    1'b0);
    chk("rst_data",  bus.cdb_data,  16'h0);
    chk("rst_tag",   bus.cdb_tag,   3'd0);
    chk("rst_op",    bus.cdb_op,    4'd0);
    chk("rst_src",   bus.cdb_src,   2'd0);
    chk("rst_count", bus.cdb_count, 16'h0);
    rst = 1'b0;
    chk("rst_ready", bus.src_ready, 3'b111);

    // Single add, two edges source-to-bus
    drive(0, 1'b1, 16'h0042, 3'd3, OP_ADD);
    push(0, 16'h0042, 3'd3, OP_ADD);
    tick();
    drive(0, 1'b0, 16'h0, 3'd0, OP_ADD);
    chk("add_lat_early", bus.cdb_valid, 1'b0);
    tick();
    chk("add_valid", bus.cdb_valid, 1'b1);
    chk("add_we",    bus.cdb_we,    1'b1);
    tick();
    chk("add_pulse", bus.cdb_valid, 1'b0);
    chk("add_count_hold", bus.cdb_count, 16'd1);

    // Three-way contention from a fresh pointer
    do_reset();
    drive(0, 1'b1, 16'h0100, 3'd1, OP_ADD);
    drive(1, 1'b1, 16'h0200, 3'd2, OP_LD);
    drive(2, 1'b1, 16'h0300, 3'd4, OP_SUB);
    push(0, 16'h0100, 3'd1, OP_ADD);
    push(1, 16'h0200, 3'd2, OP_LD);
    push(2, 16'h0300, 3'd4, OP_SUB);
    tick();
    bus.src_valid = '0;
    chk("cont_ready", bus.src_ready, 3'b001);
    drain(8);

    // src0 refilled continuously against one-shot src1/src2
    do_reset();
    drive(0, 1'b1, 16'hA000, 3'd1, OP_ADD);
    drive(1, 1'b1, 16'hB000, 3'd2, OP_LD);
    drive(2, 1'b1, 16'hC000, 3'd6, OP_SUB);
`ifdef CDB_ARB_RR_EN
    push(0, 16'hA000, 3'd1, OP_ADD);
    push(1, 16'hB000, 3'd2, OP_LD);
    push(2, 16'hC000, 3'd6, OP_SUB);
    for (int k = 1; k <= 3; k++) push(0, 16'hA000 + 16'(k), 3'd1, OP_ADD);
`else
    push(0, 16'hA000, 3'd1, OP_ADD);
    for (int k = 1; k <= 3; k++) push(0, 16'hA000 + 16'(k), 3'd1, OP_ADD);
    push(1, 16'hB000, 3'd2, OP_LD);
    push(2, 16'hC000, 3'd6, OP_SUB);
`endif
    tick();
    bus.src_valid[2:1] = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      drive(0, 1'b1, 16'hA000 + 16'(k), 3'd1, OP_ADD);
      w = 0;
      while (bus.src_ready[0] !== 1'b1 && w < 10) begin
        tick();
        w++;
      end
      if (w >= 10) chk("refill_wait", bus.src_ready[0], 1'b1);
      tick();
    end
    drive(0, 1'b0, 16'h0, 3'd0, OP_ADD);
    drain(10);

    // Store and tag-0 load broadcast without register write
    drive(2, 1'b1, 16'h0010, 3'd5, OP_SD);
    push(2, 16'h0010, 3'd5, OP_SD);
    tick();
    drive(2, 1'b0, 16'h0, 3'd0, OP_ADD);
    drive(1, 1'b1, 16'h0055, 3'd0, OP_LD);
    push(1, 16'h0055, 3'd0, OP_LD);
    tick();
    chk("sd_valid", bus.cdb_valid, 1'b1);
    chk("sd_we",    bus.cdb_we,    1'b0);
    drive(1, 1'b0, 16'h0, 3'd0, OP_ADD);
    tick();
    chk("ld0_valid", bus.cdb_valid, 1'b1);
    chk("ld0_we",    bus.cdb_we,    1'b0);
    drain(4);

    // src1 streaming alone: full rate, never back-pressured
    for (int k = 0; k < 5; k++) begin
      drive(1, 1'b1, 16'h1000 + 16'(k), 3'd2, OP_ADD);
      chk("stream_ready", bus.src_ready[1], 1'b1);
      push(1, 16'h1000 + 16'(k), 3'd2, OP_ADD);
      tick();
      if (k > 0) chk("stream_tput", bus.cdb_valid, 1'b1);
    end
    drive(1, 1'b0, 16'h0, 3'd0, OP_ADD);
    drain(6);

    // Back-pressure on src1 while src0 holds the grant
    do_reset();
    drive(0, 1'b1, 16'h0ABC, 3'd7, OP_ADD);
    drive(1, 1'b1, 16'h0BCD, 3'd4, OP_LD);
    push(0, 16'h0ABC, 3'd7, OP_ADD);
    push(1, 16'h0BCD, 3'd4, OP_LD);
    tick();
    drive(0, 1'b0, 16'h0, 3'd0, OP_ADD);
    drive(1, 1'b1, 16'h0BCE, 3'd4, OP_LD);
    chk("bp_ready_low", bus.src_ready[1], 1'b0);
    push(1, 16'h0BCE, 3'd4, OP_LD);
    tick();
    chk("bp_ready_back", bus.src_ready[1], 1'b1);
    tick();
    drive(1, 1'b0, 16'h0, 3'd0, OP_ADD);
    drain(6);

    // Reset with all slots full, then reset coinciding with a handshake
    drive(0, 1'b1, 16'hDEAD, 3'd1, OP_ADD);
    drive(1, 1'b1, 16'hBEEF, 3'd2, OP_ADD);
    drive(2, 1'b1, 16'hCAFE, 3'd3, OP_ADD);
    tick();
    bus.src_valid = '0;
    sb.delete();
    exp_cnt = 16'h0;
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", bus.cdb_valid, 1'b0);
    chk("mid_rst_data",  bus.cdb_data,  16'h0);
    chk("mid_rst_tag",   bus.cdb_tag,   3'd0);
    chk("mid_rst_op",    bus.cdb_op,    4'd0);
    chk("mid_rst_src",   bus.cdb_src,   2'd0);
    chk("mid_rst_count", bus.cdb_count, 16'h0);
    drive(1, 1'b1, 16'h7777, 3'd2, OP_ADD);
    tick();
    rst = 1'b0;
    drive(1, 1'b0, 16'h0, 3'd0, OP_ADD);
    chk("mid_rst_ready", bus.src_ready, 3'b111);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_rst_quiet", bus.cdb_valid, 1'b0);
    end

    // Counter wrap after 65536 broadcasts
    for (int i = 0; i < 65536; i++) begin
      drive(0, 1'b1, 16'(i), 3'd1, OP_ADD);
      push(0, 16'(i), 3'd1, OP_ADD);
      tick();
    end
    drive(0, 1'b0, 16'h0, 3'd0, OP_ADD);
    drain(6);
    chk("wrap_count", bus.cdb_count, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
